// File: rtl/serial_pattern_tx_pkg.sv
// rtl/serial_pattern_tx_pkg.sv - shared state encodings and default sizes for the pattern transmitter
package serial_pattern_tx_pkg;

  localparam int SP_WIDTH = 8;
  localparam int SP_LEN_W = 3;
  localparam int SP_REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } sp_state_e;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - start handshake carrying one pattern job into the transmitter
interface serial_pattern_tx_if
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH,
  parameter int LEN_W = SP_LEN_W,
  parameter int REP_W = SP_REP_W
) ();

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len_m1;
  logic [REP_W-1:0] reps;
  logic [REP_W-1:0] gap;

  modport master (
    output start_valid,
    output pattern,
    output len_m1,
    output reps,
    output gap,
    input  start_ready
  );

  modport slave (
    input  start_valid,
    input  pattern,
    input  len_m1,
    input  reps,
    input  gap,
    output start_ready
  );

endinterface

// File: rtl/sp_down_counter.sv
// rtl/sp_down_counter.sv - loadable down-counter with zero flag; load wins over decrement
module sp_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      // Saturate at zero so a stray decrement can never wrap the index.
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - Moore serial transmitter: sends a captured pattern MSB-first with
// optional repeats separated by idle gap cycles.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH,
  parameter int LEN_W = SP_LEN_W,
  parameter int REP_W = SP_REP_W
) (
  input  logic                clk,
  input  logic                rst,
  serial_pattern_tx_if.slave  start_if,
  input  logic                abort,
  output logic                tx_bit,
  output logic                tx_valid,
  output logic                busy,
  output logic                done
);

  sp_state_e        state;
  sp_state_e        state_n;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [REP_W-1:0] gap_q;
  logic             ready_q;

  logic             accept;
  logic             kill;
  logic             last_bit;
  logic             gap_exit;

  logic [LEN_W-1:0] idx;
  logic             idx_zero;
  logic             idx_load;
  logic             idx_dec;
  logic [LEN_W-1:0] idx_val;

  logic [REP_W-1:0] rep_cnt_unused;
  logic             rep_zero;
  logic             rep_dec;

  logic [REP_W-1:0] gap_cnt;
  logic             gap_zero;
  logic             gap_load;
  logic             gap_dec;

  assign start_if.start_ready = ready_q;

  always_comb begin
    accept   = (state == ST_IDLE) && start_if.start_valid;
    kill     = abort && (state != ST_IDLE);
    last_bit = (state == ST_SHIFT) && idx_zero;
    // gap_zero is a guard only; GAP is entered with a nonzero count.
    gap_exit = (state == ST_GAP) && ((gap_cnt == REP_W'(1)) || gap_zero);

    idx_load = !kill && (accept || (last_bit && !rep_zero && (gap_q == '0)) || gap_exit);
    idx_val  = accept ? start_if.len_m1 : len_q;
    idx_dec  = !kill && (state == ST_SHIFT) && !idx_zero;
    rep_dec  = !kill && last_bit && !rep_zero;
    gap_load = !kill && last_bit && !rep_zero && (gap_q != '0);
    gap_dec  = !kill && (state == ST_GAP);
  end

  sp_down_counter #(.W(LEN_W)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (idx_load),
    .load_val (idx_val),
    .dec      (idx_dec),
    .count    (idx),
    .zero     (idx_zero)
  );

  sp_down_counter #(.W(REP_W)) u_rep (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (start_if.reps),
    .dec      (rep_dec),
    .count    (rep_cnt_unused),
    .zero     (rep_zero)
  );

  sp_down_counter #(.W(REP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  always_comb begin
    state_n = state;
    if (kill) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_n = ST_SHIFT;
        ST_SHIFT: begin
          if (idx_zero) begin
            if (rep_zero)          state_n = ST_DONE;
            else if (gap_q == '0)  state_n = ST_SHIFT;
            else                   state_n = ST_GAP;
          end
        end
        ST_GAP:   if (gap_exit) state_n = ST_SHIFT;
        ST_DONE:  state_n = ST_IDLE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state <= state_n;
      if (accept) begin
        pat_q <= start_if.pattern;
        len_q <= start_if.len_m1;
        gap_q <= start_if.gap;
      end
      tx_valid <= (state_n == ST_SHIFT);
      busy     <= (state_n != ST_IDLE);
      done     <= (state_n == ST_DONE);
      ready_q  <= (state_n == ST_IDLE);
    end
  end

  assign tx_bit = tx_valid & pat_q[idx];

endmodule
